// File: rtl/spwm_duty_gen_if.sv
// spwm_duty_gen_if
//   Bundles the run/amplitude controls and the duty-word outputs of
//   spwm_duty_gen.
//   en       run request (0 = ramp amplitude down, then park)
//   amp_set  target amplitude 0..255
//   d        10-bit duty word for the PWM stage
//   sync     one-clock pulse when a new d first becomes visible
//   zero_x   one-clock pulse with sync when the sample has phase 0 and amp != 0
//   amp      current ramped amplitude
//   Modport master drives the controls; modport slave is the generator side.
interface spwm_duty_gen_if;
   logic       en;
   logic [7:0] amp_set;
   logic [9:0] d;
   logic       sync;
   logic       zero_x;
   logic [7:0] amp;

   modport master (output en, output amp_set,
                   input d, input sync, input zero_x, input amp);
   modport slave  (input en, input amp_set,
                   output d, output sync, output zero_x, output amp);
endinterface

// File: rtl/spwm_duty_gen.sv
// spwm_duty_gen
//   Sinusoidal duty-cycle generator for the single-phase bridge. Once per
//   PWM period it advances an 8-bit phase index, ramps the amplitude toward
//   its target, looks the phase up in a quarter-wave sine table, scales it by
//   the amplitude and presents the result as a duty word centred on 512.
//   The new word appears on the edge where the period counter wraps to 0.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  spwm_duty_gen_if.slave (en, amp_set in; d, sync, zero_x, amp out)
//   Parameters:
//     PERIOD     clocks per PWM period (>= 4), matches the PWM counter
//     RAMP_STEP  amplitude change per update (1..255)
module spwm_duty_gen #(
   parameter int PERIOD    = 1024,
   parameter int RAMP_STEP = 1
) (
   input logic             clk,
   input logic             rst,
   spwm_duty_gen_if.slave  bus
);

   localparam int PC_W = $clog2(PERIOD);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIOD - 1);
   localparam logic [PC_W-1:0] PC_T1   = PC_W'(PERIOD - 3);
   localparam logic signed [9:0] STEP_S = 10'(RAMP_STEP);

   logic [PC_W-1:0] pc;
   logic            t1;

   logic            vld_p0, vld_p1;
   logic [7:0]      idx_p0, amp_p0;
   logic [8:0]      mag_p1;
   logic            neg_p1;
   logic [7:0]      idx_p1, amp_p1;
   logic [9:0]      d_p2;
   logic            sync_p2, zx_p2;
   logic [7:0]      tgt;
   logic [6:0]      k_p0;

   // Amplitude ramp toward the target; lands exactly on tgt when the step overshoots.
   function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tg);
      logic signed [9:0] cur_s, tgt_s, up_s, dn_s;
      cur_s = signed'({2'b00, cur});
      tgt_s = signed'({2'b00, tg});
      up_s  = cur_s + STEP_S;
      dn_s  = cur_s - STEP_S;
      if (cur_s < tgt_s)      return (up_s > tgt_s) ? tg : up_s[7:0];
      else if (cur_s > tgt_s) return (dn_s < tgt_s) ? tg : dn_s[7:0];
      else                    return cur;
   endfunction

   // Quarter-wave table: round(511*sin(pi*k/128)), k = 0..64.
   function automatic logic [8:0] qwave(input logic [6:0] k);
      case (k)
         7'd0:  return 9'd0;   7'd1:  return 9'd13;  7'd2:  return 9'd25;  7'd3:  return 9'd38;
         7'd4:  return 9'd50;  7'd5:  return 9'd63;  7'd6:  return 9'd75;  7'd7:  return 9'd87;
         7'd8:  return 9'd100; 7'd9:  return 9'd112; 7'd10: return 9'd124; 7'd11: return 9'd136;
         7'd12: return 9'd148; 7'd13: return 9'd160; 7'd14: return 9'd172; 7'd15: return 9'd184;
         7'd16: return 9'd196; 7'd17: return 9'd207; 7'd18: return 9'd218; 7'd19: return 9'd230;
         7'd20: return 9'd241; 7'd21: return 9'd252; 7'd22: return 9'd263; 7'd23: return 9'd273;
         7'd24: return 9'd284; 7'd25: return 9'd294; 7'd26: return 9'd304; 7'd27: return 9'd314;
         7'd28: return 9'd324; 7'd29: return 9'd334; 7'd30: return 9'd343; 7'd31: return 9'd352;
         7'd32: return 9'd361; 7'd33: return 9'd370; 7'd34: return 9'd379; 7'd35: return 9'd387;
         7'd36: return 9'd395; 7'd37: return 9'd403; 7'd38: return 9'd410; 7'd39: return 9'd418;
         7'd40: return 9'd425; 7'd41: return 9'd432; 7'd42: return 9'd438; 7'd43: return 9'd445;
         7'd44: return 9'd451; 7'd45: return 9'd456; 7'd46: return 9'd462; 7'd47: return 9'd467;
         7'd48: return 9'd472; 7'd49: return 9'd477; 7'd50: return 9'd481; 7'd51: return 9'd485;
         7'd52: return 9'd489; 7'd53: return 9'd492; 7'd54: return 9'd496; 7'd55: return 9'd499;
         7'd56: return 9'd501; 7'd57: return 9'd503; 7'd58: return 9'd505; 7'd59: return 9'd507;
         7'd60: return 9'd509; 7'd61: return 9'd510; 7'd62: return 9'd510; 7'd63: return 9'd511;
         default: return 9'd511;
      endcase
   endfunction

   // Scale by amplitude (keep product bits [16:8]) and offset around mid-scale.
   // Worst case 512 +/- 509 stays inside 3..1021, so no clamp is needed.
   function automatic logic [9:0] duty(input logic [8:0] mag, input logic [7:0] a,
                                       input logic neg);
      logic [16:0] prod;
      logic [9:0]  s;
      prod = {8'd0, mag} * {9'd0, a};
      s    = {1'b0, prod[16:8]};
      return neg ? (10'd512 - s) : (10'd512 + s);
   endfunction

   assign t1  = (pc == PC_T1);
   assign tgt = bus.en ? bus.amp_set : 8'd0;
   // Odd quadrants run the table backwards.
   assign k_p0 = idx_p0[6] ? (7'd64 - {1'b0, idx_p0[5:0]}) : {1'b0, idx_p0[5:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         idx_p0  <= 8'd0;
         amp_p0  <= 8'd0;
         mag_p1  <= 9'd0;
         neg_p1  <= 1'b0;
         idx_p1  <= 8'd0;
         amp_p1  <= 8'd0;
         d_p2    <= 10'd512;
         sync_p2 <= 1'b0;
         zx_p2   <= 1'b0;
      end else begin
         pc     <= (pc == PC_LAST) ? '0 : pc + 1'b1;
         vld_p0 <= t1;
         vld_p1 <= vld_p0;

         // ---- stage 0 (T1): amplitude ramp and phase advance ----
         if (t1) begin
            amp_p0 <= ramp(amp_p0, tgt);
            // Parked (stopped with zero amplitude) pins the phase so a restart begins at idx 1.
            idx_p0 <= (!bus.en && amp_p0 == 8'd0) ? 8'd0 : idx_p0 + 8'd1;
         end

         // ---- stage 1 (T2): quarter-wave lookup ----
         if (vld_p0) begin
            mag_p1 <= qwave(k_p0);
            neg_p1 <= idx_p0[7];
            idx_p1 <= idx_p0;
            amp_p1 <= amp_p0;
         end

         // ---- stage 2 (T3): scaling, duty word and markers ----
         sync_p2 <= vld_p1;
         zx_p2   <= vld_p1 && (idx_p1 == 8'd0) && (amp_p1 != 8'd0);
         if (vld_p1) d_p2 <= duty(mag_p1, amp_p1, neg_p1);
      end
   end

   assign bus.d      = d_p2;
   assign bus.sync   = sync_p2;
   assign bus.zero_x = zx_p2;
   assign bus.amp    = amp_p0;

endmodule

// File: tb/tb_spwm_duty_gen.sv
// tb_spwm_duty_gen
//   Two generator instances share one clock: A (PERIOD 1024, step 1) for the
//   reset, ramp and mid-period reset scenarios, B (PERIOD 4, step 255) for the
//   sine points, soft stop and short-period scenarios. A behavioural model per
//   instance pushes the expected duty word at each T1; a monitor pops it when
//   the instance pulses sync and checks d, sync, zero_x and amp every cycle.
module tb_spwm_duty_gen;

   localparam int PA  = 1024;
   localparam int RSA = 1;
   localparam int PB  = 4;
   localparam int RSB = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   spwm_duty_gen_if ifa ();
   spwm_duty_gen_if ifb ();

   spwm_duty_gen #(.PERIOD(PA), .RAMP_STEP(RSA)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
   spwm_duty_gen #(.PERIOD(PB), .RAMP_STEP(RSB)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [9:0] d;
      logic       zx;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   // ---------------- reference model ----------------
   function automatic int qref(int k);
      real r;
      r = 511.0 * $sin(3.141592653589793 * real'(k) / 128.0);
      return int'($floor(r + 0.5));
   endfunction

   function automatic logic [9:0] ref_d(int idx, int amp);
      int q, k, m, s;
      q = idx / 64;
      k = idx % 64;
      m = (q == 1 || q == 3) ? qref(64 - k) : qref(k);
      s = (m * amp) / 256;
      return (q >= 2) ? 10'(512 - s) : 10'(512 + s);
   endfunction

   function automatic int ref_amp(int a, int t, int step);
      if (a < t) return (a + step > t) ? t : a + step;
      if (a > t) return (a - step < t) ? t : a - step;
      return a;
   endfunction

   function automatic int nxt_idx(logic en, int amp, int idx);
      return (!en && amp == 0) ? 0 : (idx + 1) % 256;
   endfunction

   function automatic exp_t mk_exp(int idx, int amp);
      exp_t e;
      e.d  = ref_d(idx, amp);
      e.zx = (idx == 0 && amp != 0);
      return e;
   endfunction

   int   ma_pc = 0, ma_idx = 0, ma_amp = 0;
   int   mb_pc = 0, mb_idx = 0, mb_amp = 0;
   logic ma_rst = 1'b1, mb_rst = 1'b1;

   always @(posedge clk) begin
      ma_rst <= rst_a;
      if (rst_a) begin
         ma_pc <= 0; ma_idx <= 0; ma_amp <= 0;
         qa.delete();
      end else begin
         ma_pc <= (ma_pc == PA - 1) ? 0 : ma_pc + 1;
         if (ma_pc == PA - 3) begin
            ma_amp <= ref_amp(ma_amp, ifa.en ? int'(ifa.amp_set) : 0, RSA);
            ma_idx <= nxt_idx(ifa.en, ma_amp, ma_idx);
            qa.push_back(mk_exp(nxt_idx(ifa.en, ma_amp, ma_idx),
                                ref_amp(ma_amp, ifa.en ? int'(ifa.amp_set) : 0, RSA)));
         end
      end
   end

   always @(posedge clk) begin
      mb_rst <= rst_b;
      if (rst_b) begin
         mb_pc <= 0; mb_idx <= 0; mb_amp <= 0;
         qb.delete();
      end else begin
         mb_pc <= (mb_pc == PB - 1) ? 0 : mb_pc + 1;
         if (mb_pc == PB - 3) begin
            mb_amp <= ref_amp(mb_amp, ifb.en ? int'(ifb.amp_set) : 0, RSB);
            mb_idx <= nxt_idx(ifb.en, mb_amp, mb_idx);
            qb.push_back(mk_exp(nxt_idx(ifb.en, mb_amp, mb_idx),
                                ref_amp(mb_amp, ifb.en ? int'(ifb.amp_set) : 0, RSB)));
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   task automatic mon(input bit b);
      exp_t       e;
      logic       es, ez;
      logic [9:0] ed;
      logic [9:0] od;
      logic [7:0] oa;
      logic       os, oz;
      ed = 10'd512;
      forever begin
         @(negedge clk);
         es = 1'b0;
         ez = 1'b0;
         if (b ? mb_rst : ma_rst) begin
            ed = 10'd512;
         end else if (b ? (mb_pc == 0 && qb.size() != 0) : (ma_pc == 0 && qa.size() != 0)) begin
            if (b) e = qb.pop_front();
            else   e = qa.pop_front();
            es = 1'b1;
            ez = e.zx;
            ed = e.d;
         end
         od = b ? ifb.d : ifa.d;
         oa = b ? ifb.amp : ifa.amp;
         os = b ? ifb.sync : ifa.sync;
         oz = b ? ifb.zero_x : ifa.zero_x;
         checks++;
         if (os !== es) begin errors++; $display("FAIL mon%0d_sync got %b want %b", b, os, es); end
         checks++;
         if (od !== ed) begin errors++; $display("FAIL mon%0d_d got %0d want %0d", b, od, ed); end
         checks++;
         if (oz !== ez) begin errors++; $display("FAIL mon%0d_zero_x got %b want %b", b, oz, ez); end
         checks++;
         if (oa !== 8'(b ? mb_amp : ma_amp)) begin
            errors++;
            $display("FAIL mon%0d_amp got %0d want %0d", b, oa, b ? mb_amp : ma_amp);
         end
      end
   endtask

   task automatic wait_sync(input bit b, output int cyc);
      bit hit;
      hit = 1'b0;
      cyc = 0;
      for (int i = 0; i < 2100 && !hit; i++) begin
         @(negedge clk);
         cyc++;
         if ((b ? ifb.sync : ifa.sync) === 1'b1) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL sync_timeout%0d got no pulse in %0d cycles want a pulse", b, cyc);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (5) @(negedge clk);
      checks++;
      if (ifa.d !== 10'd512) begin errors++; $display("FAIL rst_d got %0d want 512", ifa.d); end
      checks++;
      if (ifa.amp !== 8'd0 || ifa.sync !== 1'b0 || ifa.zero_x !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctl got amp=%0d sync=%b zx=%b want 0/0/0", ifa.amp, ifa.sync, ifa.zero_x);
      end
      rst_a = 1'b0;
      repeat (1023) @(negedge clk);
      checks++;
      if (ifa.sync !== 1'b0) begin errors++; $display("FAIL rel_sync1023 got %b want 0", ifa.sync); end
      @(negedge clk);
      checks++;
      if (ifa.sync !== 1'b1) begin errors++; $display("FAIL rel_sync1024 got %b want 1", ifa.sync); end
      @(negedge clk);
      checks++;
      if (ifa.sync !== 1'b0) begin errors++; $display("FAIL rel_sync1025 got %b want 0", ifa.sync); end
      repeat (1023) @(negedge clk);
      checks++;
      if (ifa.sync !== 1'b1 || ifa.d !== 10'd512) begin
         errors++;
         $display("FAIL rel_sync2048 got sync=%b d=%0d want 1/512", ifa.sync, ifa.d);
      end
   endtask

   task automatic test_ramp();
      int c, want;
      ifa.en = 1'b1;
      ifa.amp_set = 8'd3;
      for (int i = 0; i < 7; i++) begin
         wait_sync(1'b0, c);
         want = (i < 3) ? i + 1 : (i == 3) ? 3 : 6 - i;
         checks++;
         if (ifa.amp !== 8'(want)) begin
            errors++;
            $display("FAIL ramp_amp%0d got %0d want %0d", i, ifa.amp, want);
         end
         if (i == 3) ifa.amp_set = 8'd0;
      end
   endtask

   task automatic test_reset_mid();
      int c;
      ifa.amp_set = 8'd255;
      for (int i = 0; i < 40; i++) begin
         wait_sync(1'b0, c);
         if (ifa.d !== 10'd512) break;
      end
      repeat (500) @(negedge clk);
      checks++;
      if (ifa.d === 10'd512) begin errors++; $display("FAIL mid_pre_d got %0d want not 512", ifa.d); end
      rst_a = 1'b1;
      @(negedge clk);
      checks++;
      if (ifa.d !== 10'd512 || ifa.amp !== 8'd0) begin
         errors++;
         $display("FAIL mid_rst got d=%0d amp=%0d want 512/0", ifa.d, ifa.amp);
      end
      rst_a = 1'b0;
      repeat (1023) @(negedge clk);
      checks++;
      if (ifa.sync !== 1'b0) begin errors++; $display("FAIL mid_sync1023 got %b want 0", ifa.sync); end
      @(negedge clk);
      checks++;
      if (ifa.sync !== 1'b1) begin errors++; $display("FAIL mid_sync1024 got %b want 1", ifa.sync); end
      ifa.en = 1'b0;
   endtask

   task automatic test_sine();
      int c;
      rst_b = 1'b0;
      ifb.en = 1'b1;
      ifb.amp_set = 8'd255;
      for (int n = 1; n <= 257; n++) begin
         wait_sync(1'b1, c);
         checks++;
         if (c !== PB) begin errors++; $display("FAIL short_interval%0d got %0d want %0d", n, c, PB); end
         if (n == 1) begin
            checks++;
            if (ifb.amp !== 8'd255 || ifb.d !== 10'd524) begin
               errors++;
               $display("FAIL sine_idx1 got amp=%0d d=%0d want 255/524", ifb.amp, ifb.d);
            end
         end
         if (n == 32 || n == 64 || n == 128 || n == 192) begin
            checks++;
            if (ifb.d !== ((n == 32) ? 10'd871 : (n == 64) ? 10'd1021 : (n == 128) ? 10'd512 : 10'd3)) begin
               errors++;
               $display("FAIL sine_idx%0d got d=%0d want %0d", n, ifb.d,
                        (n == 32) ? 871 : (n == 64) ? 1021 : (n == 128) ? 512 : 3);
            end
         end
         if (n == 255 || n == 256) begin
            checks++;
            if (ifb.zero_x !== (n == 256)) begin
               errors++;
               $display("FAIL sine_zx%0d got %b want %b", n, ifb.zero_x, n == 256);
            end
         end
      end
   endtask

   task automatic test_soft_stop();
      int c;
      ifb.en = 1'b0;
      wait_sync(1'b1, c);
      checks++;
      if (ifb.amp !== 8'd0 || ifb.d !== 10'd512) begin
         errors++;
         $display("FAIL stop_first got amp=%0d d=%0d want 0/512", ifb.amp, ifb.d);
      end
      for (int i = 0; i < 6; i++) begin
         wait_sync(1'b1, c);
         checks++;
         if (ifb.d !== 10'd512 || ifb.zero_x !== 1'b0) begin
            errors++;
            $display("FAIL stop_park%0d got d=%0d zx=%b want 512/0", i, ifb.d, ifb.zero_x);
         end
      end
   endtask

   task automatic test_restart();
      int c;
      ifb.en = 1'b1;
      wait_sync(1'b1, c);
      checks++;
      if (ifb.amp !== 8'd255 || ifb.d !== 10'd524 || ifb.zero_x !== 1'b0) begin
         errors++;
         $display("FAIL restart got amp=%0d d=%0d zx=%b want 255/524/0", ifb.amp, ifb.d, ifb.zero_x);
      end
   endtask

   initial begin
      ifa.en = 1'b0; ifa.amp_set = 8'd0;
      ifb.en = 1'b0; ifb.amp_set = 8'd0;
      rst_a = 1'b1;  rst_b = 1'b1;
      @(posedge clk);
      fork
         mon(1'b0);
         mon(1'b1);
      join_none
      test_reset();
      test_ramp();
      test_reset_mid();
      test_sine();
      test_soft_stop();
      test_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
